// File: rtl/router_port_arbiter_if.sv
// Handshake bundle between the route-compute request matrix, one output-port
// arbiter and the forward mux / downstream credit return.
interface router_port_arbiter_if #(
   parameter int unsigned NUM_PORTS    = 5,
   parameter int unsigned CREDIT_DEPTH = 4
);
   localparam int unsigned CW = $clog2(CREDIT_DEPTH + 1);
   localparam int unsigned IW = $clog2(NUM_PORTS);

   logic [NUM_PORTS-1:0] req_i;
   logic [NUM_PORTS-1:0] hi_pri_i;
   logic                 pri_en_i;
   logic [NUM_PORTS-1:0] tail_i;
   logic                 credit_i;
   logic [NUM_PORTS-1:0] grant_o;
   logic                 grant_valid_o;
   logic [IW-1:0]        grant_idx_o;
   logic                 locked_o;
   logic [CW-1:0]        credits_o;
   logic                 credit_err_o;

   modport slave (
      input  req_i, hi_pri_i, pri_en_i, tail_i, credit_i,
      output grant_o, grant_valid_o, grant_idx_o, locked_o, credits_o, credit_err_o
   );

   modport master (
      output req_i, hi_pri_i, pri_en_i, tail_i, credit_i,
      input  grant_o, grant_valid_o, grant_idx_o, locked_o, credits_o, credit_err_o
   );
endinterface

// File: rtl/router_port_arbiter.sv
// Per-output-port wormhole scheduler: round-robin with optional priority class,
// head-to-tail lock and downstream credit tracking.
module router_port_arbiter #(
   parameter int unsigned NUM_PORTS    = 5,
   parameter int unsigned CREDIT_DEPTH = 4
) (
   input logic                  clk,
   input logic                  rst,
   router_port_arbiter_if.slave bus
);
   localparam int unsigned CW = $clog2(CREDIT_DEPTH + 1);
   localparam int unsigned IW = $clog2(NUM_PORTS);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [IW-1:0]        r_owner, w_owner_nxt;
   logic [IW-1:0]        r_rr_ptr, w_rr_nxt;
   logic [CW-1:0]        r_credits, w_credits_nxt;
   logic                 r_credit_err, w_credit_err_nxt;

   logic [NUM_PORTS-1:0] w_hi_req;
   logic [NUM_PORTS-1:0] w_cand;
   logic [IW-1:0]        w_win_idx;
   logic                 w_win_found;
   logic [NUM_PORTS-1:0] w_grant;
   logic [IW-1:0]        w_grant_idx;
   logic                 w_fire;

   function automatic logic [IW-1:0] next_port(input logic [IW-1:0] p);
      return (32'(p) == NUM_PORTS - 1) ? '0 : p + 1'b1;
   endfunction

   // Round-robin pick among candidates, scanning upward from rr_ptr
   always_comb begin
      int unsigned k;
      k           = 0;
      w_hi_req    = bus.req_i & bus.hi_pri_i;
      w_cand      = (bus.pri_en_i && (|w_hi_req)) ? w_hi_req : bus.req_i;
      w_win_idx   = '0;
      w_win_found = 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         k = 32'(r_rr_ptr) + i;
         if (k >= NUM_PORTS) k = k - NUM_PORTS;
         if (!w_win_found && w_cand[IW'(k)]) begin
            w_win_idx   = IW'(k);
            w_win_found = 1'b1;
         end
      end
   end

   // Next-state and grant; nothing is granted in reset or without a credit
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_rr_nxt    = r_rr_ptr;
      w_grant     = '0;
      w_grant_idx = '0;
      if (!rst && (r_credits != '0)) begin
         case (r_state)
            S_IDLE: begin
               if (w_win_found) begin
                  w_grant[w_win_idx] = 1'b1;
                  w_grant_idx        = w_win_idx;
                  if (bus.tail_i[w_win_idx]) begin
                     w_rr_nxt = next_port(w_win_idx);
                  end else begin
                     w_state_nxt = S_LOCKED;
                     w_owner_nxt = w_win_idx;
                  end
               end
            end
            S_LOCKED: begin
               if (bus.req_i[r_owner]) begin
                  w_grant[r_owner] = 1'b1;
                  w_grant_idx      = r_owner;
                  if (bus.tail_i[r_owner]) begin
                     w_state_nxt = S_IDLE;
                     w_rr_nxt    = next_port(r_owner);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign w_fire = |w_grant;

   // Credit counter: a fire consumes a slot, a returned credit frees one
   always_comb begin
      w_credits_nxt    = r_credits;
      w_credit_err_nxt = r_credit_err;
      case ({w_fire, bus.credit_i})
         2'b10: w_credits_nxt = r_credits - 1'b1;
         2'b01: begin
            if (32'(r_credits) == CREDIT_DEPTH) w_credit_err_nxt = 1'b1;
            else                                w_credits_nxt    = r_credits + 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_owner      <= '0;
         r_rr_ptr     <= '0;
         r_credits    <= CW'(CREDIT_DEPTH);
         r_credit_err <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_rr_ptr     <= w_rr_nxt;
         r_credits    <= w_credits_nxt;
         r_credit_err <= w_credit_err_nxt;
      end
   end

   assign bus.grant_o       = w_grant;
   assign bus.grant_valid_o = w_fire;
   assign bus.grant_idx_o   = w_grant_idx;
   assign bus.locked_o      = (r_state == S_LOCKED);
   assign bus.credits_o     = r_credits;
   assign bus.credit_err_o  = r_credit_err;
endmodule

// File: tb/tb_router_port_arbiter.sv
// Vector-table bench for router_port_arbiter with an expected-output queue.
module tb_router_port_arbiter;
   typedef struct {
      logic       rst;
      logic [4:0] req;
      logic [4:0] hi;
      logic       pri;
      logic [4:0] tail;
      logic       crd;
      logic       gv;
      logic [2:0] idx;
      logic       lk;
      logic [2:0] cr;
      logic       err;
   } vec_t;

   typedef struct {
      logic [4:0] grant;
      logic       gv;
      logic [2:0] idx;
      logic       lk;
      logic [2:0] cr;
      logic       err;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t sb_q[$];
   vec_t vecs[39];

   router_port_arbiter_if #(.NUM_PORTS(5), .CREDIT_DEPTH(4)) bus ();

   router_port_arbiter #(.NUM_PORTS(5), .CREDIT_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [4:0] rq, input logic [4:0] h,
                               input logic p, input logic [4:0] t, input logic c,
                               input logic g, input logic [2:0] ix, input logic l,
                               input logic [2:0] cr, input logic e);
      vec_t v;
      v.rst = r; v.req = rq; v.hi = h; v.pri = p; v.tail = t; v.crd = c;
      v.gv = g; v.idx = ix; v.lk = l; v.cr = cr; v.err = e;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive on the falling edge, queue the expectation, compare just before the rising edge
   task automatic apply(input vec_t v, input string tag);
      exp_t       e;
      exp_t       got;
      logic [4:0] one;
      @(negedge clk);
      rst          = v.rst;
      bus.req_i    = v.req;
      bus.hi_pri_i = v.hi;
      bus.pri_en_i = v.pri;
      bus.tail_i   = v.tail;
      bus.credit_i = v.crd;
      one          = 5'b00001;
      e.grant      = v.gv ? (one << v.idx) : 5'b00000;
      e.gv         = v.gv;
      e.idx        = v.gv ? v.idx : 3'd0;
      e.lk         = v.lk;
      e.cr         = v.cr;
      e.err        = v.err;
      sb_q.push_back(e);
      #3;
      got = sb_q.pop_front();
      chk({tag, ".grant"},  int'(bus.grant_o),       int'(got.grant));
      chk({tag, ".gvalid"}, int'(bus.grant_valid_o), int'(got.gv));
      chk({tag, ".idx"},    int'(bus.grant_idx_o),   int'(got.idx));
      chk({tag, ".locked"}, int'(bus.locked_o),      int'(got.lk));
      chk({tag, ".credits"},int'(bus.credits_o),     int'(got.cr));
      chk({tag, ".err"},    int'(bus.credit_err_o),  int'(got.err));
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      bus.req_i    = '0;
      bus.hi_pri_i = '0;
      bus.pri_en_i = 1'b0;
      bus.tail_i   = '0;
      bus.credit_i = 1'b0;

      //               rst req       hi        pri tail      crd  gv idx lk cr err
      vecs[0]  = mk(1, 5'b11111, 5'b00000, 0, 5'b11111, 0,  0, 0, 0, 4, 0);
      // alternating single-flit grants with credit return every cycle
      vecs[1]  = mk(0, 5'b10001, 5'b00000, 0, 5'b11111, 1,  1, 0, 0, 4, 0);
      vecs[2]  = mk(0, 5'b10001, 5'b00000, 0, 5'b11111, 1,  1, 4, 0, 4, 0);
      vecs[3]  = mk(0, 5'b10001, 5'b00000, 0, 5'b11111, 1,  1, 0, 0, 4, 0);
      vecs[4]  = mk(0, 5'b10001, 5'b00000, 0, 5'b11111, 1,  1, 4, 0, 4, 0);
      // priority class on, then off after reset
      vecs[5]  = mk(0, 5'b00111, 5'b00100, 1, 5'b11111, 0,  1, 2, 0, 4, 0);
      vecs[6]  = mk(1, 5'b00111, 5'b00100, 1, 5'b11111, 0,  0, 0, 0, 3, 0);
      vecs[7]  = mk(0, 5'b00111, 5'b00100, 0, 5'b11111, 0,  1, 0, 0, 4, 0);
      // 3-flit packet on input 1 while input 3 waits
      vecs[8]  = mk(0, 5'b01010, 5'b01000, 0, 5'b11101, 1,  1, 1, 0, 3, 0);
      vecs[9]  = mk(0, 5'b01010, 5'b01000, 0, 5'b11101, 1,  1, 1, 1, 3, 0);
      vecs[10] = mk(0, 5'b01010, 5'b01000, 0, 5'b11111, 1,  1, 1, 1, 3, 0);
      vecs[11] = mk(0, 5'b01000, 5'b01000, 0, 5'b11111, 0,  1, 3, 0, 3, 0);
      // drain credits to zero, stall, resume on one returned credit
      vecs[12] = mk(1, 5'b00001, 5'b00000, 0, 5'b11111, 0,  0, 0, 0, 2, 0);
      vecs[13] = mk(0, 5'b00001, 5'b00000, 0, 5'b11111, 0,  1, 0, 0, 4, 0);
      vecs[14] = mk(0, 5'b00001, 5'b00000, 0, 5'b11111, 0,  1, 0, 0, 3, 0);
      vecs[15] = mk(0, 5'b00001, 5'b00000, 0, 5'b11111, 0,  1, 0, 0, 2, 0);
      vecs[16] = mk(0, 5'b00001, 5'b00000, 0, 5'b11111, 0,  1, 0, 0, 1, 0);
      vecs[17] = mk(0, 5'b00001, 5'b00000, 0, 5'b11111, 0,  0, 0, 0, 0, 0);
      vecs[18] = mk(0, 5'b00001, 5'b00000, 0, 5'b11111, 1,  0, 0, 0, 0, 0);
      vecs[19] = mk(0, 5'b00001, 5'b00000, 0, 5'b11111, 0,  1, 0, 0, 1, 0);
      vecs[20] = mk(0, 5'b00001, 5'b00000, 0, 5'b11111, 0,  0, 0, 0, 0, 0);
      // fire plus credit at 2, then overflow sets the sticky error
      vecs[21] = mk(0, 5'b00000, 5'b00000, 0, 5'b11111, 1,  0, 0, 0, 0, 0);
      vecs[22] = mk(0, 5'b00000, 5'b00000, 0, 5'b11111, 1,  0, 0, 0, 1, 0);
      vecs[23] = mk(0, 5'b00001, 5'b00000, 0, 5'b11111, 1,  1, 0, 0, 2, 0);
      vecs[24] = mk(0, 5'b00000, 5'b00000, 0, 5'b11111, 0,  0, 0, 0, 2, 0);
      vecs[25] = mk(0, 5'b00000, 5'b00000, 0, 5'b11111, 1,  0, 0, 0, 2, 0);
      vecs[26] = mk(0, 5'b00000, 5'b00000, 0, 5'b11111, 1,  0, 0, 0, 3, 0);
      vecs[27] = mk(0, 5'b00000, 5'b00000, 0, 5'b11111, 1,  0, 0, 0, 4, 0);
      vecs[28] = mk(0, 5'b00000, 5'b00000, 0, 5'b11111, 0,  0, 0, 0, 4, 1);
      vecs[29] = mk(0, 5'b00001, 5'b00000, 0, 5'b11111, 0,  1, 0, 0, 4, 1);
      // lock on input 2, owner bubbles while others (even hi-pri) request
      vecs[30] = mk(0, 5'b00100, 5'b00000, 0, 5'b11011, 0,  1, 2, 0, 3, 1);
      vecs[31] = mk(0, 5'b00001, 5'b00000, 0, 5'b11111, 0,  0, 0, 1, 2, 1);
      vecs[32] = mk(0, 5'b01001, 5'b01000, 1, 5'b11111, 0,  0, 0, 1, 2, 1);
      vecs[33] = mk(0, 5'b00001, 5'b00000, 0, 5'b11111, 0,  0, 0, 1, 2, 1);
      vecs[34] = mk(0, 5'b00101, 5'b00000, 0, 5'b11111, 0,  1, 2, 1, 2, 1);
      vecs[35] = mk(0, 5'b00000, 5'b00000, 0, 5'b11111, 1,  0, 0, 0, 1, 1);
      // reset in the middle of a packet
      vecs[36] = mk(0, 5'b00010, 5'b00000, 0, 5'b11101, 0,  1, 1, 0, 2, 1);
      vecs[37] = mk(1, 5'b00010, 5'b00000, 0, 5'b11101, 0,  0, 0, 1, 1, 1);
      vecs[38] = mk(0, 5'b00000, 5'b00000, 0, 5'b11111, 0,  0, 0, 0, 4, 0);

      repeat (2) @(posedge clk);

      for (int i = 0; i < 39; i++) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // all inputs requesting: pointer walks 0..4 one packet at a time
      for (int i = 0; i < 5; i++) begin
         apply(mk(0, 5'b11111, 5'b00000, 0, 5'b11111, 1, 1, 3'(i), 0, 4, 0),
               $sformatf("rr%0d", i));
      end
      // pointer wrapped to 0; priority class picks input 4 over lower indices
      apply(mk(0, 5'b11111, 5'b10000, 1, 5'b11111, 1, 1, 4, 0, 4, 0), "pri_wrap");
      apply(mk(0, 5'b00011, 5'b00000, 0, 5'b11111, 1, 1, 0, 0, 4, 0), "after_wrap");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
